// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C target: FSM state encoding and bus-level constants.
package i2c_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        ADDR_ACK,
        RX_BYTE,
        RX_ACK,
        TX_BYTE,
        TX_ACK,
        IGNORE
    } i2c_slv_state_t;

    localparam logic [6:0] I2C_GENERAL_CALL_ADDR = 7'h00;
    localparam logic       I2C_ACK               = 1'b0;
    localparam logic       I2C_NACK              = 1'b1;

endpackage

// File: rtl/i2c_bus_sync.sv
// SCL/SDA input synchroniser with single-cycle SCL edge and START/STOP condition detection.
module i2c_bus_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk_en,
    input  logic rst,
    input  logic scl,
    input  logic sda,
    output logic sda_s,
    output logic scl_rise,
    output logic scl_fall,
    output logic start_det,
    output logic stop_det
);

    logic [SYNC_STAGES-1:0] scl_sync;
    logic [SYNC_STAGES-1:0] sda_sync;
    logic                   scl_d;
    logic                   sda_d;
    logic                   scl_s;

    // Idle bus level is high, so everything resets to 1 to avoid a false START after reset.
    always_ff @(posedge clk_en or negedge rst) begin
        if (!rst) begin
            scl_sync <= '1;
            sda_sync <= '1;
            scl_d    <= 1'b1;
            sda_d    <= 1'b1;
        end else begin
            scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl};
            sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda};
            scl_d    <= scl_sync[SYNC_STAGES-1];
            sda_d    <= sda_sync[SYNC_STAGES-1];
        end
    end

    assign scl_s     = scl_sync[SYNC_STAGES-1];
    assign sda_s     = sda_sync[SYNC_STAGES-1];
    assign scl_rise  = scl_s & ~scl_d;
    assign scl_fall  = ~scl_s & scl_d;
    assign start_det = scl_s & scl_d & sda_d & ~sda_s;
    assign stop_det  = scl_s & scl_d & ~sda_d & sda_s;

endmodule

// File: rtl/i2c_slave.sv
// I2C target: 7-bit address match, RX/TX FIFO strobes, open-drain SDA, no clock stretching.
// Define I2C_SLAVE_GENERAL_CALL_EN to ACK the general-call write address (8'h00).
module i2c_slave
    import i2c_pkg::*;
#(
    parameter logic [6:0] SLAVE_ADDR  = 7'h50,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       clk_en,
    input  logic       rst,
    input  logic       scl,
    inout  wire        sda,
    input  logic [7:0] tx_data,
    input  logic       tx_empty,
    output logic       tx_rd,
    output logic [7:0] rx_data,
    output logic       rx_wr,
    output logic       busy,
    output logic       addr_hit,
    output logic       stop_det
);

    logic sda_s, scl_rise, scl_fall, start_cond, stop_cond;

    i2c_bus_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk_en   (clk_en),
        .rst      (rst),
        .scl      (scl),
        .sda      (sda),
        .sda_s    (sda_s),
        .scl_rise (scl_rise),
        .scl_fall (scl_fall),
        .start_det(start_cond),
        .stop_det (stop_cond)
    );

    i2c_slv_state_t state, state_n;
    logic [2:0] bit_cnt, bit_cnt_n;
    logic [7:0] shift_reg, shift_n;
    logic [7:0] rx_data_n, tx_byte;
    logic       byte_done, byte_done_n;
    logic       sda_out, sda_out_n;
    logic       tx_rd_n, rx_wr_n, busy_n, addr_hit_n, stop_det_n;
    logic       addr_match;

    // sda_out is the level we want on the bus: 0 pulls low, 1 releases.
    assign sda = sda_out ? 1'bz : 1'b0;

    always_ff @(posedge clk_en or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            bit_cnt   <= 3'd0;
            shift_reg <= 8'd0;
            byte_done <= 1'b0;
            sda_out   <= 1'b1;
            tx_rd     <= 1'b0;
            rx_wr     <= 1'b0;
            rx_data   <= 8'd0;
            busy      <= 1'b0;
            addr_hit  <= 1'b0;
            stop_det  <= 1'b0;
        end else begin
            state     <= state_n;
            bit_cnt   <= bit_cnt_n;
            shift_reg <= shift_n;
            byte_done <= byte_done_n;
            sda_out   <= sda_out_n;
            tx_rd     <= tx_rd_n;
            rx_wr     <= rx_wr_n;
            rx_data   <= rx_data_n;
            busy      <= busy_n;
            addr_hit  <= addr_hit_n;
            stop_det  <= stop_det_n;
        end
    end

    // Evaluated on the 8th address bit: shift_reg[6:0] holds the address, sda_s is R/W.
    always_comb begin
`ifdef I2C_SLAVE_GENERAL_CALL_EN
        addr_match = ((shift_reg[6:0] == SLAVE_ADDR) && (shift_reg[6:0] != I2C_GENERAL_CALL_ADDR))
                   || ((shift_reg[6:0] == I2C_GENERAL_CALL_ADDR) && (sda_s == 1'b0));
`else
        addr_match = (shift_reg[6:0] == SLAVE_ADDR) && (shift_reg[6:0] != I2C_GENERAL_CALL_ADDR);
`endif
    end

    assign tx_byte = tx_empty ? 8'hFF : tx_data;

    always_comb begin
        state_n     = state;
        bit_cnt_n   = bit_cnt;
        shift_n     = shift_reg;
        byte_done_n = byte_done;
        sda_out_n   = sda_out;
        tx_rd_n     = 1'b0;
        rx_wr_n     = 1'b0;
        rx_data_n   = rx_data;
        busy_n      = busy;
        addr_hit_n  = addr_hit;
        stop_det_n  = 1'b0;

        if (start_cond) begin
            state_n     = ADDR;
            bit_cnt_n   = 3'd0;
            byte_done_n = 1'b0;
            sda_out_n   = 1'b1;
            busy_n      = 1'b1;
            addr_hit_n  = 1'b0;
        end else if (stop_cond) begin
            state_n     = IDLE;
            byte_done_n = 1'b0;
            sda_out_n   = 1'b1;
            stop_det_n  = 1'b1;
            busy_n      = 1'b0;
            addr_hit_n  = 1'b0;
        end else begin
            case (state)
                IDLE, IGNORE: sda_out_n = 1'b1;
                ADDR: begin
                    if (scl_rise) begin
                        shift_n   = {shift_reg[6:0], sda_s};
                        bit_cnt_n = bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            if (addr_match) byte_done_n = 1'b1;
                            else            state_n     = IGNORE;
                        end
                    end else if (scl_fall && byte_done) begin
                        sda_out_n   = I2C_ACK;
                        byte_done_n = 1'b0;
                        addr_hit_n  = 1'b1;
                        state_n     = ADDR_ACK;
                    end
                end
                ADDR_ACK: begin
                    if (scl_fall) begin
                        bit_cnt_n = 3'd0;
                        if (shift_reg[0] == 1'b0) begin
                            sda_out_n = 1'b1;
                            state_n   = RX_BYTE;
                        end else begin
                            tx_rd_n   = ~tx_empty;
                            shift_n   = tx_byte;
                            sda_out_n = tx_byte[7];
                            state_n   = TX_BYTE;
                        end
                    end
                end
                RX_BYTE: begin
                    if (scl_rise) begin
                        shift_n   = {shift_reg[6:0], sda_s};
                        bit_cnt_n = bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            rx_wr_n     = 1'b1;
                            rx_data_n   = {shift_reg[6:0], sda_s};
                            byte_done_n = 1'b1;
                        end
                    end else if (scl_fall && byte_done) begin
                        sda_out_n   = I2C_ACK;
                        byte_done_n = 1'b0;
                        state_n     = RX_ACK;
                    end
                end
                RX_ACK: begin
                    if (scl_fall) begin
                        sda_out_n = 1'b1;
                        bit_cnt_n = 3'd0;
                        state_n   = RX_BYTE;
                    end
                end
                TX_BYTE: begin
                    if (scl_fall) begin
                        if (bit_cnt == 3'd7) begin
                            sda_out_n   = 1'b1;
                            bit_cnt_n   = 3'd0;
                            byte_done_n = 1'b0;
                            state_n     = TX_ACK;
                        end else begin
                            shift_n   = {shift_reg[6:0], 1'b0};
                            sda_out_n = shift_reg[6];
                            bit_cnt_n = bit_cnt + 3'd1;
                        end
                    end
                end
                TX_ACK: begin
                    if (scl_rise) begin
                        if (sda_s == I2C_NACK) state_n     = IGNORE;
                        else                   byte_done_n = 1'b1;
                    end else if (scl_fall && byte_done) begin
                        byte_done_n = 1'b0;
                        tx_rd_n     = ~tx_empty;
                        shift_n     = tx_byte;
                        sda_out_n   = tx_byte[7];
                        bit_cnt_n   = 3'd0;
                        state_n     = TX_BYTE;
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_slave.sv
// Scoreboard bench for i2c_slave: bit-banged I2C master, queue-based RX/read-data checking.
module tb_i2c_slave;

    localparam int QTR = 5;

    logic       clk_en = 1'b0;
    logic       rst    = 1'b0;
    logic       m_scl  = 1'b1;
    logic       m_sda  = 1'b1;
    wire        sda;
    logic [7:0] tx_data  = 8'h00;
    logic       tx_empty = 1'b1;
    logic       tx_rd, rx_wr, busy, addr_hit, stop_det;
    logic [7:0] rx_data;

    logic [7:0] exp_rx[$];
    logic [7:0] exp_rd[$];
    logic [7:0] tx_src[$];

    int   num_compared   = 0;
    int   num_mismatched = 0;
    int   rx_count, tx_count, stop_count;
    logic dut_low_seen, hit_seen, busy_dropped;
    logic track_busy = 1'b0;
    logic ack;
    logic [7:0] exp_b;

    i2c_slave #(.SLAVE_ADDR(7'h50), .SYNC_STAGES(2)) dut (
        .clk_en  (clk_en),
        .rst     (rst),
        .scl     (m_scl),
        .sda     (sda),
        .tx_data (tx_data),
        .tx_empty(tx_empty),
        .tx_rd   (tx_rd),
        .rx_data (rx_data),
        .rx_wr   (rx_wr),
        .busy    (busy),
        .addr_hit(addr_hit),
        .stop_det(stop_det)
    );

    assign sda = m_sda ? 1'bz : 1'b0;
    pullup (sda);

    always #5 clk_en = ~clk_en;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        num_compared++;
        if (observed !== expected) begin
            num_mismatched++;
            $display("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic scl_v, input logic sda_v);
        @(negedge clk_en);
        #2;
        m_scl = scl_v;
        m_sda = sda_v;
        repeat (QTR - 1) @(negedge clk_en);
    endtask

    task automatic updateTx();
        tx_empty = (tx_src.size() == 0);
        tx_data  = tx_empty ? 8'h00 : tx_src[0];
    endtask

    task automatic clearCounts();
        rx_count     = 0;
        tx_count     = 0;
        stop_count   = 0;
        dut_low_seen = 1'b0;
        hit_seen     = 1'b0;
        busy_dropped = 1'b0;
    endtask

    task automatic i2cStart();
        applyStimulus(1'b0, 1'b1);
        applyStimulus(1'b1, 1'b1);
        applyStimulus(1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0);
    endtask

    task automatic i2cStop();
        applyStimulus(1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0);
        applyStimulus(1'b1, 1'b1);
    endtask

    task automatic writeBits(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) begin
            applyStimulus(1'b0, b[i]);
            applyStimulus(1'b1, b[i]);
            applyStimulus(1'b1, b[i]);
            applyStimulus(1'b0, b[i]);
        end
    endtask

    task automatic i2cWriteByte(input logic [7:0] b, output logic ack_o);
        writeBits(b);
        applyStimulus(1'b0, 1'b1);
        applyStimulus(1'b1, 1'b1);
        ack_o = sda;
        applyStimulus(1'b1, 1'b1);
        applyStimulus(1'b0, 1'b1);
    endtask

    task automatic i2cReadByte(input logic nack, output logic [7:0] b);
        for (int i = 7; i >= 0; i--) begin
            applyStimulus(1'b0, 1'b1);
            applyStimulus(1'b1, 1'b1);
            b[i] = sda;
            applyStimulus(1'b1, 1'b1);
            applyStimulus(1'b0, 1'b1);
        end
        applyStimulus(1'b0, nack);
        applyStimulus(1'b1, nack);
        applyStimulus(1'b1, nack);
        applyStimulus(1'b0, nack);
    endtask

    task automatic readCheck(input string tag, input logic [7:0] expected, input logic nack);
        logic [7:0] got;
        logic [7:0] e;
        exp_rd.push_back(expected);
        i2cReadByte(nack, got);
        e = exp_rd.pop_front();
        checkOutput(tag, got, e);
    endtask

    // Bus/strobe monitor: pops the RX scoreboard and serves the TX source queue.
    always @(negedge clk_en) begin
        if (rx_wr) begin
            rx_count++;
            if (exp_rx.size() > 0) begin
                exp_b = exp_rx.pop_front();
                checkOutput("rx_data", rx_data, exp_b);
            end
        end
        if (tx_rd) begin
            tx_count++;
            if (tx_src.size() > 0) void'(tx_src.pop_front());
            updateTx();
        end
        if (stop_det) stop_count++;
        if (addr_hit) hit_seen = 1'b1;
        if (m_sda && sda === 1'b0) dut_low_seen = 1'b1;
        if (track_busy && !busy) busy_dropped = 1'b1;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", num_compared, num_mismatched + 1);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        clearCounts();
        repeat (4) @(negedge clk_en);
        checkOutput("reset_tx_rd", tx_rd, 1'b0);
        checkOutput("reset_rx_wr", rx_wr, 1'b0);
        checkOutput("reset_busy", busy, 1'b0);
        checkOutput("reset_addr_hit", addr_hit, 1'b0);
        checkOutput("reset_stop_det", stop_det, 1'b0);
        checkOutput("reset_sda", sda, 1'b1);
        rst = 1'b1;
        repeat (5) @(negedge clk_en);

        $display("[TB] write 0x3C, 0xC3");
        clearCounts();
        i2cStart();
        checkOutput("wr_busy", busy, 1'b1);
        i2cWriteByte(8'hA0, ack);
        checkOutput("wr_addr_ack", ack, 1'b0);
        checkOutput("wr_addr_hit", addr_hit, 1'b1);
        exp_rx.push_back(8'h3C);
        i2cWriteByte(8'h3C, ack);
        checkOutput("wr_d0_ack", ack, 1'b0);
        exp_rx.push_back(8'hC3);
        i2cWriteByte(8'hC3, ack);
        checkOutput("wr_d1_ack", ack, 1'b0);
        i2cStop();
        repeat (10) @(negedge clk_en);
        checkOutput("wr_rx_count", rx_count, 2);
        checkOutput("wr_stop_count", stop_count, 1);
        checkOutput("wr_busy_after", busy, 1'b0);
        checkOutput("wr_addr_hit_after", addr_hit, 1'b0);

        $display("[TB] read 0x5A, 0x81");
        clearCounts();
        tx_src = '{8'h5A, 8'h81};
        updateTx();
        i2cStart();
        i2cWriteByte(8'hA1, ack);
        checkOutput("rd_addr_ack", ack, 1'b0);
        readCheck("rd_byte0", 8'h5A, 1'b0);
        readCheck("rd_byte1", 8'h81, 1'b1);
        i2cStop();
        repeat (10) @(negedge clk_en);
        checkOutput("rd_tx_count", tx_count, 2);
        checkOutput("rd_sda_released", sda, 1'b1);

        $display("[TB] address mismatch");
        clearCounts();
        i2cStart();
        i2cWriteByte(8'hA4, ack);
        checkOutput("mm_addr_nack", ack, 1'b1);
        i2cWriteByte(8'h55, ack);
        i2cStop();
        repeat (10) @(negedge clk_en);
        checkOutput("mm_sda_never_low", dut_low_seen, 1'b0);
        checkOutput("mm_rx_count", rx_count, 0);
        checkOutput("mm_tx_count", tx_count, 0);
        checkOutput("mm_addr_hit", hit_seen, 1'b0);

        $display("[TB] repeated start");
        clearCounts();
        tx_src = '{8'h77};
        updateTx();
        i2cStart();
        track_busy = 1'b1;
        i2cWriteByte(8'hA0, ack);
        checkOutput("sr_addr_w_ack", ack, 1'b0);
        exp_rx.push_back(8'h11);
        i2cWriteByte(8'h11, ack);
        checkOutput("sr_d0_ack", ack, 1'b0);
        i2cStart();
        i2cWriteByte(8'hA1, ack);
        checkOutput("sr_addr_r_ack", ack, 1'b0);
        readCheck("sr_rd_byte", 8'h77, 1'b1);
        track_busy = 1'b0;
        i2cStop();
        repeat (10) @(negedge clk_en);
        checkOutput("sr_rx_count", rx_count, 1);
        checkOutput("sr_tx_count", tx_count, 1);
        checkOutput("sr_busy_held", busy_dropped, 1'b0);

        $display("[TB] read with empty TX FIFO");
        clearCounts();
        tx_src.delete();
        updateTx();
        i2cStart();
        i2cWriteByte(8'hA1, ack);
        checkOutput("em_addr_ack", ack, 1'b0);
        readCheck("em_rd_byte", 8'hFF, 1'b1);
        i2cStop();
        repeat (10) @(negedge clk_en);
        checkOutput("em_tx_count", tx_count, 0);

        $display("[TB] general call address");
        clearCounts();
        i2cStart();
        i2cWriteByte(8'h00, ack);
`ifdef I2C_SLAVE_GENERAL_CALL_EN
        checkOutput("gc_ack", ack, 1'b0);
`else
        checkOutput("gc_nack", ack, 1'b1);
`endif
        i2cStop();
        repeat (10) @(negedge clk_en);
        checkOutput("gc_stop_count", stop_count, 1);

        $display("[TB] reset during address ACK");
        clearCounts();
        i2cStart();
        writeBits(8'hA0);
        applyStimulus(1'b0, 1'b1);
        applyStimulus(1'b1, 1'b1);
        checkOutput("rs_ack_driven", sda, 1'b0);
        @(posedge clk_en);
        #3;
        rst = 1'b0;
        #1;
        checkOutput("rs_sda_released", sda, 1'b1);
        checkOutput("rs_busy", busy, 1'b0);
        checkOutput("rs_addr_hit", addr_hit, 1'b0);
        repeat (3) @(negedge clk_en);
        rst = 1'b1;
        repeat (5) @(negedge clk_en);
        i2cStart();
        i2cWriteByte(8'hA0, ack);
        checkOutput("rs_recover_ack", ack, 1'b0);
        i2cStop();
        repeat (10) @(negedge clk_en);
        checkOutput("rs_recover_busy", busy, 1'b0);
        checkOutput("rx_scoreboard_empty", exp_rx.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", num_compared, num_mismatched);
        $finish;
    end

endmodule
